log2_frac: RTL and testbench
============================

# log2_frac

Fractional log2 stage placed directly downstream of the leading-one / normalization stage. It accepts an integer exponent and a normalized mantissa in [1,2), and produces a fixed-point log2 value. The integer part is passed through unchanged. The fractional part is computed by iterative squaring, one result bit per cycle. Its output feeds the log-compression / dB scaling stage of the ultrasound envelope path.

## Interface
- `SHIFT_WIDTH`, default 4: width of the integer exponent (log2 of 16-bit sample width).
- `NORM_WIDTH`, default 17: mantissa width; format 1.(NORM_WIDTH-1), MSB is the implicit leading one.
- `FRAC_BITS`, default 8: number of fractional log2 bits produced.
- `OUT_WIDTH`, default SHIFT_WIDTH+FRAC_BITS: output width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream has a valid exponent/mantissa pair.
- `in_ready` out 1: block can accept an input; high only in IDLE.
- `int_part` in SHIFT_WIDTH: integer log2 (MSB index) from upstream.
- `data_in` in NORM_WIDTH: normalized mantissa.
- `out_valid` out 1: `log_out` is valid.
- `out_ready` in 1: downstream accepts `log_out`.
- `log_out` out OUT_WIDTH: {integer part, FRAC_BITS fractional bits}, unsigned fixed point.

## Operation
- FSM states: IDLE, ITER, DONE.
  - IDLE: `in_ready`=1. On `in_valid` high, latch `int_part`, latch `data_in` into mantissa register m with its MSB forced to 1, clear bit counter, clear fraction register, go to ITER.
  - ITER: one iteration per cycle, FRAC_BITS cycles total.
  - DONE: `out_valid`=1. Stay in DONE until `out_ready`=1, then go to IDLE.
- Iteration:
  - p = m*m, full 2*NORM_WIDTH-bit unsigned product. p has 2 integer bits and 2*(NORM_WIDTH-1) fractional bits, so p is in [1,4).
  - If p[2*NORM_WIDTH-1]=1 (p ≥ 2): the result bit is 1 and m_next = p[2*NORM_WIDTH-1 -: NORM_WIDTH].
  - Otherwise the result bit is 0 and m_next = p[2*NORM_WIDTH-2 -: NORM_WIDTH].
  - Truncation only, no rounding. m_next MSB is always 1.
  - Result bits shift into the fraction register MSB-first: the first iteration produces the 2^-1 bit.
- On the last ITER cycle, register `log_out` = {latched int_part, fraction} and set `out_valid`.
- `log_out` and `out_valid` are held stable while in DONE. `log_out` keeps its last value after the handshake, until it is overwritten by the next result.
- Inputs are ignored outside IDLE; there is no skid buffer.
- Upstream always supplies data_in MSB=1. If it does not, the forced MSB defines the behaviour.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert via `clk`) sets:
  - state=IDLE
  - `out_valid`=0
  - `log_out`=0
  - internal registers=0
  - `in_ready`=1 (combinational from state)
- Input accepted at edge t (IDLE, `in_valid`=1). Iterations complete at edges t+1 … t+FRAC_BITS. `out_valid` is high from edge t+FRAC_BITS.
- Output handshake at edge u (DONE, `out_ready`=1). `out_valid` falls and `in_ready` rises at edge u.
- Minimum input-to-input spacing: FRAC_BITS+2 cycles (10 with the default FRAC_BITS=8).
- `out_ready` is ignored outside DONE. `in_valid` and `out_ready` may both be high in DONE; only the output handshake occurs in that cycle.
- Reset asserted mid-ITER or in DONE aborts the in-flight sample with no output. The first cycle after release is IDLE.

## Test plan
- int_part=5, data_in=0x10000 (1.0) -> `log_out`=0x500, `out_valid` rises 8 cycles after accept.
- int_part=3, data_in=0x18000 (1.5) -> `log_out`=0x395 (frac 0x95, floor of 0.585·256).
- int_part=0, data_in=0x16A0A (√2) -> `log_out`=0x080.
- int_part=15, data_in=0x1FFFF -> `log_out`=0xFFF (all fractional ones, no overflow).
- Hold `out_ready`=0 for 5 cycles in DONE with `in_valid`=1 -> `log_out` and `out_valid` stable, `in_ready`=0, no input accepted. Raise `out_ready` -> handshake, then the next input is accepted the following cycle.
- Assert `reset` (low) during the 4th ITER cycle -> `out_valid` and `log_out` go to 0 immediately. After release, a new sample int_part=5, data_in=0x10000 -> `log_out`=0x500.

Source files
------------

// File: rtl/log2_frac.sv
// Fractional log2 by iterative squaring: the integer part passes through and
// FRAC_BITS fractional bits are produced one per cycle, MSB first.
module log2_frac #(
    parameter int SHIFT_WIDTH = 4,
    parameter int NORM_WIDTH  = 17,
    parameter int FRAC_BITS   = 8,
    parameter int OUT_WIDTH   = SHIFT_WIDTH + FRAC_BITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SHIFT_WIDTH-1:0] int_part,
    input  logic [NORM_WIDTH-1:0]  data_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   log_out
);

    localparam int CNT_WIDTH  = (FRAC_BITS > 1) ? $clog2(FRAC_BITS) : 1;
    localparam int PROD_WIDTH = 2 * NORM_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    state_t state, state_next;

    logic [SHIFT_WIDTH-1:0] int_q;
    logic [NORM_WIDTH-1:0]  m_q;
    logic [NORM_WIDTH-1:0]  m_next;
    logic [FRAC_BITS-1:0]   frac_q;
    logic [FRAC_BITS-1:0]   frac_next;
    logic [CNT_WIDTH-1:0]   bit_cnt;
    logic [PROD_WIDTH-1:0]  prod;
    logic                   res_bit;
    logic                   last_iter;
    logic                   accept;
    logic                   release_out;
    logic                   prod_unused;

    assign in_ready    = (state == IDLE);
    assign accept      = in_ready && in_valid;
    assign release_out = (state == DONE) && out_ready;
    assign last_iter   = (bit_cnt == CNT_WIDTH'(FRAC_BITS - 1));

    // m is 1.(N-1) in [1,2), so m*m is 2.(2N-2) in [1,4); the top bit decides
    // the result bit and which N-bit window renormalises m back into [1,2).
    assign prod        = PROD_WIDTH'(m_q) * PROD_WIDTH'(m_q);
    assign res_bit     = prod[PROD_WIDTH-1];
    assign m_next      = res_bit ? prod[PROD_WIDTH-1 -: NORM_WIDTH]
                                 : prod[PROD_WIDTH-2 -: NORM_WIDTH];
    assign frac_next   = {frac_q[FRAC_BITS-2:0], res_bit};
    // Truncated product bits are dropped on purpose.
    assign prod_unused = ^prod[PROD_WIDTH-NORM_WIDTH-2:0];

    // NOTE: state and data registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the default assignment first keeps this block free of latches
    // even when a case arm does not assign state_next.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)  state_next = ITER;
            ITER: if (last_iter) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // NOTE: every datapath register is reset, so an aborted sample leaves no
    // residue and log_out reads zero straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_q     <= '0;
            m_q       <= '0;
            frac_q    <= '0;
            bit_cnt   <= '0;
            log_out   <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            int_q   <= int_part;
            m_q     <= {1'b1, data_in[NORM_WIDTH-2:0]};
            frac_q  <= '0;
            bit_cnt <= '0;
        end else if (state == ITER) begin
            m_q     <= m_next;
            frac_q  <= frac_next;
            bit_cnt <= bit_cnt + 1'b1;
            if (last_iter) begin
                log_out   <= OUT_WIDTH'({int_q, frac_next});
                out_valid <= 1'b1;
            end
        end else if (release_out) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_log2_frac.sv
// Self-checking bench for log2_frac: directed samples, a transaction-level
// reference model, and a per-cycle compare of all outputs.
module tb_log2_frac;

    localparam int SW = 4;
    localparam int NW = 17;
    localparam int FB = 8;
    localparam int OW = SW + FB;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [SW-1:0] int_part = '0;
    logic [NW-1:0] data_in = '0;
    logic          in_ready;
    logic          out_valid;
    logic [OW-1:0] log_out;

    int vectors = 0;
    int miscompares = 0;

    log2_frac #(
        .SHIFT_WIDTH(SW),
        .NORM_WIDTH (NW),
        .FRAC_BITS  (FB),
        .OUT_WIDTH  (OW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .int_part (int_part),
        .data_in  (data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .log_out  (log_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // log2 of a mantissa in [1,2) by repeated squaring on plain integers:
    // m is scaled by 2^16, m*m by 2^32, so m*m >= 2.0 means >= 2^33.
    function automatic logic [OW-1:0] ref_log(input logic [SW-1:0] ip, input logic [NW-1:0] d);
        longint        m;
        longint        p;
        logic [FB-1:0] f;
        m = longint'({1'b1, d[NW-2:0]});
        f = '0;
        for (int i = 0; i < FB; i++) begin
            p = m * m;
            if (p >= (longint'(1) << 33)) begin
                f = {f[FB-2:0], 1'b1};
                m = p >>> 17;
            end else begin
                f = {f[FB-2:0], 1'b0};
                m = p >>> 16;
            end
        end
        return {ip, f};
    endfunction

    // Transaction-level model: accept, wait FB cycles, present, hand off.
    typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_t;
    mphase_t       m_phase = M_IDLE;
    int            m_left = 0;
    logic [OW-1:0] m_pending = '0;
    logic [OW-1:0] m_log = '0;
    logic          m_valid = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase <= M_IDLE;
            m_left  <= 0;
            m_log   <= '0;
            m_valid <= 1'b0;
        end else begin
            case (m_phase)
                M_IDLE: if (in_valid) begin
                    m_pending <= ref_log(int_part, data_in);
                    m_left    <= FB;
                    m_phase   <= M_BUSY;
                end
                M_BUSY: if (m_left == 1) begin
                    m_log   <= m_pending;
                    m_valid <= 1'b1;
                    m_phase <= M_DONE;
                end else begin
                    m_left <= m_left - 1;
                end
                M_DONE: if (out_ready) begin
                    m_valid <= 1'b0;
                    m_phase <= M_IDLE;
                end
                default: m_phase <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        check("cyc_in_ready", 32'(in_ready), 32'(m_phase == M_IDLE));
        check("cyc_out_valid", 32'(out_valid), 32'(m_valid));
        check("cyc_log_out", 32'(log_out), 32'(m_log));
    end

    task automatic send(input logic [SW-1:0] ip, input logic [NW-1:0] d);
        check("send_in_ready", 32'(in_ready), 32'd1);
        int_part = ip;
        data_in  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [SW-1:0] ip;
        logic [NW-1:0] d;
        logic [OW-1:0] exp;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int            lat;
        logic [OW-1:0] held;

        vecs[0] = '{4'd5,  17'h10000, 12'h500};
        vecs[1] = '{4'd3,  17'h18000, 12'h395};
        vecs[2] = '{4'd0,  17'h16A0A, 12'h080};
        vecs[3] = '{4'd15, 17'h1FFFF, 12'hFFF};

        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_log_out", 32'(log_out), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            check($sformatf("model_%0d", i), 32'(ref_log(vecs[i].ip, vecs[i].d)), 32'(vecs[i].exp));
            // Vector 1 keeps out_ready high throughout: ignored until DONE.
            if (i == 1) out_ready = 1'b1;
            send(vecs[i].ip, vecs[i].d);
            wait_out(lat);
            check($sformatf("latency_%0d", i), 32'(lat), 32'(FB));
            check($sformatf("log_out_%0d", i), 32'(log_out), 32'(vecs[i].exp));
            handshake();
            check($sformatf("post_hs_valid_%0d", i), 32'(out_valid), 32'd0);
        end

        // Backpressure in DONE with a competing input.
        send(4'd2, 17'h1C000);
        wait_out(lat);
        held = log_out;
        check("bp_log_out", 32'(held), 32'(ref_log(4'd2, 17'h1C000)));
        int_part = 4'd7;
        data_in  = 17'h14000;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_log", 32'(log_out), 32'(held));
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_valid", 32'(out_valid), 32'd0);
        check("bp_hs_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_next_accepted", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_out(lat);
        check("bp_next_latency", 32'(lat), 32'(FB));
        check("bp_next_log", 32'(log_out), 32'(ref_log(4'd7, 17'h14000)));
        handshake();

        // Reset during the 4th ITER cycle aborts the sample.
        send(4'd9, 17'h13000);
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_log_out", 32'(log_out), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send(4'd5, 17'h10000);
        wait_out(lat);
        check("after_rst_latency", 32'(lat), 32'(FB));
        check("after_rst_log", 32'(log_out), 32'h500);
        handshake();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
